// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, frame constants and parity helper for the PS/2 receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;
    // True when data plus parity bit carry an odd number of ones.
    function automatic logic parity_ok(input logic [DATA_BITS:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: first-word-fall-through circular FIFO with occupancy count.
module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    // A pop frees a slot, so a simultaneous push is accepted even when full.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with clock glitch filter, parity/stop
// checking, inactivity timeout and a FWFT byte FIFO towards the scan-code decoder.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2d,
    input  logic             ps2c,
    input  logic             rx_en,
    input  logic             rd_en,
    output logic [7:0]       dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             rx_done_tick,
    output logic             parity_err_tick,
    output logic             frame_err_tick,
    output logic             overflow_tick
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [1:0] c_sync_q, c_sync_d, d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic f_ps2c_q, f_ps2c_d, fall;
    state_t state_q, state_d;
    logic [3:0] n_q, n_d;
    logic [DATA_BITS+1:0] b_q, b_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic push;
    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
        filt_d   = {c_sync_q[1], filt_q[FILTER_LEN-1:1]};
        f_ps2c_d = (&filt_q) ? 1'b1 : (~|filt_q) ? 1'b0 : f_ps2c_q;
        fall     = f_ps2c_q & ~f_ps2c_d;
    end
    // b_q collects {stop, parity, d7..d0}; the start bit is only checked, never stored.
    always_comb begin
        state_d         = state_q;
        n_d             = n_q;
        b_d             = b_q;
        tmo_d           = (fall || state_q != SHIFT) ? '0 : tmo_q + TW'(1);
        push            = 1'b0;
        rx_done_tick    = 1'b0;
        parity_err_tick = 1'b0;
        frame_err_tick  = 1'b0;
        overflow_tick   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall && rx_en) begin
                    if (!d_sync_q[1]) begin
                        b_d     = '0;
                        n_d     = 4'(FRAME_BITS - 2);
                        state_d = SHIFT;
                    end else begin
                        frame_err_tick = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (fall) begin
                    b_d     = {d_sync_q[1], b_q[DATA_BITS+1:1]};
                    n_d     = n_q - 4'd1;
                    state_d = (n_q == 4'd0) ? CHECK : SHIFT;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    frame_err_tick = 1'b1;
                    state_d        = IDLE;
                end
            end
            CHECK: begin
                state_d         = IDLE;
                frame_err_tick  = ~b_q[DATA_BITS+1];
                parity_err_tick = b_q[DATA_BITS+1] & ~parity_ok(b_q[DATA_BITS:0]);
                overflow_tick   = b_q[DATA_BITS+1] & parity_ok(b_q[DATA_BITS:0]) & full & ~rd_en;
                push            = b_q[DATA_BITS+1] & parity_ok(b_q[DATA_BITS:0]) & ~(full & ~rd_en);
                rx_done_tick    = push;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            filt_q   <= '1;
            f_ps2c_q <= 1'b1;
            state_q  <= IDLE;
            n_q      <= '0;
            b_q      <= '0;
            tmo_q    <= '0;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            filt_q   <= filt_d;
            f_ps2c_q <= f_ps2c_d;
            state_q  <= state_d;
            n_q      <= n_d;
            b_q      <= b_d;
            tmo_q    <= tmo_d;
        end
    end
    ps2_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (b_q[DATA_BITS-1:0]),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count)
    );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed scenarios for the PS/2 receiver with FIFO.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;
    localparam int FL = 8, TO = 300, DEPTH = 8, CW = $clog2(DEPTH) + 1;
    logic clk = 0, reset = 0, ps2d = 1, ps2c = 1, rx_en = 1, rd_en = 0;
    logic [7:0] dout;
    logic empty, full, rx_done_tick, parity_err_tick, frame_err_tick, overflow_tick;
    logic [CW-1:0] count;
    int checks = 0, failures = 0;
    int n_done = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
    int d0, p0, f0, o0;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en),
        .dout(dout), .empty(empty), .full(full), .count(count),
        .rx_done_tick(rx_done_tick), .parity_err_tick(parity_err_tick),
        .frame_err_tick(frame_err_tick), .overflow_tick(overflow_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (rx_done_tick) n_done++;
        if (parity_err_tick) n_perr++;
        if (frame_err_tick) n_ferr++;
        if (overflow_tick) n_ovf++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic snap();
        d0 = n_done; p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
    endtask
    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            ps2d = f[i];
            wait_clk(20);
            ps2c = 0;
            wait_clk(40);
            ps2c = 1;
            wait_clk(20);
        end
    endtask
    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit stop);
        return {stop, ~^b ^ bad_par, b, 1'b0};
    endfunction
    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit stop);
        send_bits(frame(b, bad_par, stop), 0, 11);
        ps2d = 1;
        wait_clk(20);
    endtask
    task automatic pop_one();
        rd_en = 1;
        wait_clk(1);
        rd_en = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        wait_clk(3);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (count !== 0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++; if ({rx_done_tick, parity_err_tick, frame_err_tick, overflow_tick} !== 4'b0) begin
            failures++; $display("FAIL reset_ticks: got %b expected 0000",
                {rx_done_tick, parity_err_tick, frame_err_tick, overflow_tick}); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
        reset = 1;
        wait_clk(30);
    endtask

    task automatic test_good();
        snap();
        send_byte(8'h1C, 0, 1);
        checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL good_done: got %0d expected 1", n_done - d0); end
        checks++; if (dout !== 8'h1C) begin failures++; $display("FAIL good_dout: got %h expected 1c", dout); end
        checks++; if (count !== 1) begin failures++; $display("FAIL good_count: got %0d expected 1", count); end
        checks++; if (n_perr - p0 + n_ferr - f0 !== 0) begin failures++; $display("FAIL good_errs: got %0d expected 0", n_perr - p0 + n_ferr - f0); end
        pop_one();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL good_pop_empty: got %b expected 1", empty); end
    endtask

    task automatic test_errors();
        snap();
        send_byte(8'h1C, 1, 1);
        checks++; if (n_perr - p0 !== 1) begin failures++; $display("FAIL parity_tick: got %0d expected 1", n_perr - p0); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL parity_empty: got %b expected 1", empty); end
        snap();
        send_byte(8'h1C, 0, 0);
        checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL stop_tick: got %0d expected 1", n_ferr - f0); end
        checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL stop_done: got %0d expected 0", n_done - d0); end
        snap();
        send_bits(11'h7FF, 0, 1);
        checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL start_tick: got %0d expected 1", n_ferr - f0); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL start_state: got %0d expected IDLE", dut.state_q); end
    endtask

    task automatic test_timeout();
        snap();
        send_bits(frame(8'h55, 0, 1), 0, 5);
        ps2d = 1;
        checks++; if (dut.state_q !== SHIFT) begin failures++; $display("FAIL tmo_inframe: got %0d expected SHIFT", dut.state_q); end
        wait_clk(TO + 10);
        checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL tmo_tick: got %0d expected 1", n_ferr - f0); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL tmo_state: got %0d expected IDLE", dut.state_q); end
        send_byte(8'hF0, 0, 1);
        checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL tmo_next_done: got %0d expected 1", n_done - d0); end
        checks++; if (dout !== 8'hF0) begin failures++; $display("FAIL tmo_next_dout: got %h expected f0", dout); end
        pop_one();
    endtask

    task automatic test_overflow();
        snap();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 0, 1);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full: got %b expected 1", full); end
        checks++; if (count !== 8) begin failures++; $display("FAIL ovf_count: got %0d expected 8", count); end
        send_byte(8'h09, 0, 1);
        checks++; if (n_ovf - o0 !== 1) begin failures++; $display("FAIL ovf_tick: got %0d expected 1", n_ovf - o0); end
        checks++; if (n_done - d0 !== 8) begin failures++; $display("FAIL ovf_done: got %0d expected 8", n_done - d0); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (dout !== 8'(i)) begin failures++; $display("FAIL ovf_read%0d: got %h expected %h", i, dout, 8'(i)); end
            pop_one();
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_drained: got %b expected 1", empty); end
        pop_one();
        checks++; if (count !== 0) begin failures++; $display("FAIL pop_empty_count: got %0d expected 0", count); end
    endtask

    task automatic test_glitch_rx_en();
        snap();
        ps2d = 1;
        ps2c = 0;
        wait_clk(FL - 2);
        ps2c = 1;
        wait_clk(40);
        checks++; if (n_ferr - f0 !== 0) begin failures++; $display("FAIL glitch_fall: got %0d expected 0", n_ferr - f0); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL glitch_state: got %0d expected IDLE", dut.state_q); end
        rx_en = 0;
        send_byte(8'h1C, 0, 1);
        checks++; if (n_done - d0 + n_ferr - f0 !== 0) begin failures++; $display("FAIL rxen_off: got %0d expected 0", n_done - d0 + n_ferr - f0); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rxen_off_empty: got %b expected 1", empty); end
        rx_en = 1;
        send_bits(frame(8'hA5, 0, 1), 0, 3);
        rx_en = 0;
        send_bits(frame(8'hA5, 0, 1), 3, 11);
        ps2d = 1;
        wait_clk(20);
        rx_en = 1;
        checks++; if (dout !== 8'hA5) begin failures++; $display("FAIL rxen_mid_dout: got %h expected a5", dout); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        send_byte(8'h11, 0, 1);
        send_byte(8'h22, 0, 1);
        send_byte(8'h33, 0, 1);
        checks++; if (count !== 3) begin failures++; $display("FAIL mid_count3: got %0d expected 3", count); end
        send_bits(frame(8'h77, 0, 1), 0, 5);
        snap();
        reset = 0;
        wait_clk(2);
        checks++; if (count !== 0 || empty !== 1'b1) begin failures++; $display("FAIL mid_fifo: got count=%0d empty=%b expected 0/1", count, empty); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL mid_state: got %0d expected IDLE", dut.state_q); end
        ps2d = 1;
        reset = 1;
        wait_clk(30);
        checks++; if (n_done - d0 + n_ferr - f0 + n_perr - p0 !== 0) begin failures++; $display("FAIL mid_pulses: got %0d expected 0", n_done - d0 + n_ferr - f0 + n_perr - p0); end
        send_byte(8'h5A, 0, 1);
        checks++; if (dout !== 8'h5A || count !== 1) begin failures++; $display("FAIL mid_next: got %h/%0d expected 5a/1", dout, count); end
    endtask

    initial begin
        test_reset();
        test_good();
        test_errors();
        test_timeout();
        test_overflow();
        test_glitch_rx_en();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with glitch filtering, odd-parity and stop-bit checking, inactivity timeout, and a first-word-fall-through output FIFO. It sits between the keyboard pins and the scan-code decoder. It replaces the single-byte receiver, whose data is lost if the consumer misses the done tick.

## Interface
- FILTER_LEN, 8: samples of the synchronised ps2c that must agree before the filtered clock changes (≥2).
- TIMEOUT_CYC, 50000: clk cycles without a ps2c falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
- FIFO_DEPTH, 8: FIFO entries; power of two, ≥2.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of `count`.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2d  in  1  PS/2 data pin, asynchronous.
- ps2c  in  1  PS/2 clock pin, asynchronous.
- rx_en  in  1  allows a new frame to start.
- rd_en  in  1  pops the FIFO head; ignored when empty.
- dout  out  8  FIFO head byte, valid while !empty; 8'h00 when empty.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  CNT_W  number of stored bytes.
- rx_done_tick  out  1  one-cycle pulse when a good byte is written to the FIFO.
- parity_err_tick  out  1  one-cycle pulse on a parity failure; the byte is discarded.
- frame_err_tick  out  1  one-cycle pulse on a bad start bit, a bad stop bit, or a timeout; the frame is discarded.
- overflow_tick  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Input synchronisation:** ps2c and ps2d each pass through a 2-flop synchroniser.
- **Clock filter:** the synchronised ps2c feeds a FILTER_LEN-bit shift register.
  - f_ps2c goes to 1 when all bits are 1, and to 0 when all bits are 0.
  - fall = f_ps2c_q & ~f_ps2c.
- **Frame format:** 11 bits (start 0, d0..d7 LSB first, odd parity, stop 1), sampled on fall.
- **FSM states:** IDLE, SHIFT, CHECK.
  - IDLE: on fall with rx_en=1 and ps2d_sync=0, load the shift register, set bit counter n=9, and go to SHIFT. If ps2d_sync=1 at start, stay in IDLE and pulse frame_err_tick.
  - SHIFT: on each fall, shift ps2d_sync into the MSB of the 10-bit register and decrement n. After the fall with n=0 (stop bit captured), go to CHECK.
  - CHECK (one cycle), evaluated in priority order:
    1. stop=0 → frame_err_tick.
    2. ^{data,parity}=0 → parity_err_tick.
    3. full=1 and rd_en=0 → overflow_tick.
    4. otherwise push the byte and pulse rx_done_tick.
    
    Always return to IDLE.
- **Timeout:** the timeout counter clears on every fall and counts up in SHIFT. Reaching TIMEOUT_CYC-1 → pulse frame_err_tick, go to IDLE, discard partial data.
- **rx_en:** sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- **FIFO:**
  - Circular buffer; pointers wrap modulo FIFO_DEPTH; count tracks occupancy.
  - Push and pop in the same cycle: count is unchanged; allowed even when full, because the pop frees the slot.
  - Pop when empty: no effect.

## Timing
- Reset values: every output 0 except empty=1. FSM=IDLE, f_ps2c=1 and filter register all-ones (no spurious fall), pointers and counters 0.
- Pin falling edge → fall: 2 + FILTER_LEN clk cycles.
- Stop-bit fall → CHECK on the next cycle. rx_done_tick and the write occur in the CHECK cycle; empty deasserts and dout is valid the cycle after.
- rd_en pop: dout shows the next entry the cycle after the pop (FWFT).
- Minimum PS/2 bit period supported: 4·(FILTER_LEN+4) clk cycles.
- Reset asserted mid-frame: the FSM, FIFO, and all ticks return to reset values immediately (asynchronous). No pulse is emitted.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, SHIFT, CHECK);
  - FRAME_BITS=11 and DATA_BITS=8;
  - a parity function.
- Sub-module ps2_sync_fifo (parameters DEPTH and WIDTH=8): FWFT FIFO with push, pop, dout, empty, full, and count.
- The top level contains the synchroniser, filter, FSM, timeout counter, and error logic.

## Test plan
- Good frame, 0x1C: bits 0,0,0,1,1,1,0,0,0,P=0,1 → rx_done_tick once, dout=8'h1C, count=1, no error ticks.
- Same frame with P=1 → parity_err_tick once, empty stays 1.
- Stop bit 0 → frame_err_tick. Send 5 bits, then hold ps2c high for TIMEOUT_CYC+10 cycles → frame_err_tick, FSM returns to IDLE, and the next good 0xF0 frame is received correctly.
- With FIFO_DEPTH=8, send 9 good frames 0x01..0x09 with rd_en=0 → full=1 after 8, overflow_tick on the 9th. Reads then return 0x01..0x08 in order, and empty=1 after 8 pops.
- A ps2c low glitch of FILTER_LEN-2 cycles → no fall and no state change. Frames sent with rx_en=0 → nothing received.
- reset pulsed low mid-frame and mid-FIFO (3 bytes stored) → count=0, empty=1, FSM=IDLE, and the following frame is received correctly.
